// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared types and defaults for the pipeline stage buffer (pipe_stage_buf).
//
// Contents:
//   pipe_state_e        occupancy state of a stage: EMPTY, ONE, FULL
//   PIPE_DEFAULT_WIDTH  default payload width
//   PIPE_DEFAULT_CNT_W  default performance counter width
//                       (present only when PIPE_STAGE_PERF_EN is defined)
//   pipe_slot_count()   number of valid slots (0..2) for a given state
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // neither slot valid
        ONE   = 2'd1,   // main slot valid
        FULL  = 2'd2    // main and skid slots valid
    } pipe_state_e;

    localparam int unsigned PIPE_DEFAULT_WIDTH = 250;

`ifdef PIPE_STAGE_PERF_EN
    localparam int unsigned PIPE_DEFAULT_CNT_W = 32;
`endif

    // Occupancy of a state. The unused encoding counts as empty.
    function automatic logic [1:0] pipe_slot_count(input pipe_state_e s);
        logic [1:0] n;
        case (s)
            ONE:     n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_sat_cnt.sv
// ----------------------------------------------------------------------------
// pipe_sat_cnt
// Saturating up-counter with a variable increment amount. The count sticks at
// 2^CNT_W-1 once reached.
//
// Parameters:
//   CNT_W   counter width
//   INC_W   width of the increment amount
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset, clears the count
//   inc_i   amount added this cycle (0 = no change)
//   cnt_o   current count
// ----------------------------------------------------------------------------
module pipe_sat_cnt #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned INC_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned SUM_W = CNT_W + INC_W;
    localparam logic [SUM_W-1:0] SAT_MAX = {{INC_W{1'b0}}, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SUM_W-1:0] sum;

    // The sum is wide enough that it can never wrap, so a plain compare
    // against the maximum detects saturation for any CNT_W/INC_W.
    always_comb begin
        sum = SUM_W'(cnt_q) + SUM_W'(inc_i);
        if (sum > SAT_MAX) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : pipe_sat_cnt

// File: rtl/pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. Sustains one transfer per cycle while keeping in_ready registered,
// and keeps the legacy hold (freeze) and flush (squash to bubble) semantics.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   defined   -> stall_cnt / flush_cnt ports and saturating counters present
//   undefined -> ports and counter logic absent, handshake unchanged
//
// Parameters:
//   WIDTH        payload width (>= 1)
//   FLUSH_VALUE  payload value presented by an empty or flushed slot
//   CNT_W        performance counter width (PIPE_STAGE_PERF_EN only)
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   hold       global stall: no transfer on either side, all state frozen
//   flush      synchronous squash of all held entries (hold has priority)
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  main slot holds a valid payload (registered)
//   out_ready  downstream accepts
//   out_data   main slot payload (registered)
//   stall_cnt  cycles with out_valid and (not out_ready or hold)
//   flush_cnt  valid entries discarded by flush
// ----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned      CNT_W       = PIPE_DEFAULT_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             out_valid_q;
    logic             in_ready_q;

    logic accept;
    logic emit;

    // Both handshakes are qualified by hold so that a stalled pipeline neither
    // consumes nor produces a payload even when valid and ready are high.
    assign accept = in_valid & in_ready_q & ~hold;
    assign emit   = out_valid_q & out_ready & ~hold;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (!hold) begin
            if (flush) begin
                // Same-cycle in_data is dropped along with the held entries.
                state_d = EMPTY;
                main_d  = FLUSH_VALUE;
                skid_d  = FLUSH_VALUE;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            state_d = ONE;
                            main_d  = in_data;
                        end
                    end
                    ONE: begin
                        if (accept && emit) begin
                            main_d  = in_data;
                        end else if (accept) begin
                            state_d = FULL;
                            skid_d  = in_data;
                        end else if (emit) begin
                            state_d = EMPTY;
                            main_d  = FLUSH_VALUE;
                        end
                    end
                    FULL: begin
                        // in_ready is low in FULL, so only an emit can occur.
                        if (emit) begin
                            state_d = ONE;
                            main_d  = skid_q;
                            skid_d  = FLUSH_VALUE;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                        main_d  = FLUSH_VALUE;
                        skid_d  = FLUSH_VALUE;
                    end
                endcase
            end
        end
    end

    // The handshake outputs are decoded from the next state and registered,
    // so neither out_valid nor in_ready has a combinational input path.
    // NOTE: the data registers are reset as well, because an empty stage must
    // present FLUSH_VALUE on out_data straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_q      <= FLUSH_VALUE;
            skid_q      <= FLUSH_VALUE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= (pipe_slot_count(state_d) != 2'd0);
            in_ready_q  <= (state_d != FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [1:0] stall_inc;
    logic [1:0] flush_inc;

    // A stall cycle is any cycle where a valid payload is not leaving,
    // whether due to downstream backpressure or the global hold.
    assign stall_inc = {1'b0, out_valid_q & (~out_ready | hold)};

    // A flush only takes effect when not held; it discards every valid slot.
    assign flush_inc = (flush && !hold) ? pipe_slot_count(state_q) : 2'd0;

    pipe_sat_cnt #(
        .CNT_W (CNT_W),
        .INC_W (2)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_W (CNT_W),
        .INC_W (2)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );
`endif

endmodule : pipe_stage_buf

// File: tb/tb_pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_buf
// Directed self-checking bench for pipe_stage_buf (WIDTH=8, FLUSH_VALUE=0,
// CNT_W=3 when PIPE_STAGE_PERF_EN is defined). Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int unsigned W = 8;
    localparam int unsigned CW = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         hold;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .WIDTH       (W),
        .FLUSH_VALUE ('0)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W       (CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .hold      (hold),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reset asserted while FULL with in_valid high clears everything at once.
    task automatic test_reset();
        do_reset();
        in_valid = 1'b1; in_data = 8'hA1;
        tick();
        in_data = 8'hB2;
        tick();
        tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_pre_in_ready: got %0b want 0", in_ready); end
        n_vec++; if (out_data !== 8'hA1) begin n_err++; $display("FAIL reset_pre_out_data: got %0h want a1", out_data); end
`ifdef PIPE_STAGE_PERF_EN
        n_vec++; if (stall_cnt !== 3'd2) begin n_err++; $display("FAIL reset_pre_stall_cnt: got %0d want 2", stall_cnt); end
`endif
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
`ifdef PIPE_STAGE_PERF_EN
        n_vec++; if (stall_cnt !== 3'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        n_vec++; if (flush_cnt !== 3'd0) begin n_err++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); end
`endif
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_post_out_valid: got %0b want 0", out_valid); end
    endtask

    // Data 1..100 streams through with 1-cycle latency and in_ready stuck high.
    task automatic test_streaming();
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            in_data = W'(i);
            tick();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); end
            n_vec++; if (out_data !== W'(i)) begin n_err++; $display("FAIL stream_data[%0d]: got %0d want %0d", i, out_data, i); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %0b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL stream_drain_data: got %0h want 0", out_data); end
    endtask

    // A,B,C with the sink stalled: C is refused, then A,B,C drain in order.
    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; in_data = 8'h0A;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_c1: got %0b want 1", in_ready); end
        n_vec++; if (out_data !== 8'h0A) begin n_err++; $display("FAIL bp_data_c1: got %0h want 0a", out_data); end
        in_data = 8'h0B;
        tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_c2: got %0b want 0", in_ready); end
        in_data = 8'h0C;
        tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_c3: got %0b want 0", in_ready); end
        n_vec++; if (out_data !== 8'h0A) begin n_err++; $display("FAIL bp_data_c3: got %0h want 0a", out_data); end
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_data !== 8'h0B) begin n_err++; $display("FAIL bp_data_b: got %0h want 0b", out_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise: got %0b want 1", in_ready); end
        tick();
        n_vec++; if (out_data !== 8'h0C) begin n_err++; $display("FAIL bp_data_c: got %0h want 0c", out_data); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_c: got %0b want 1", out_valid); end
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
    endtask

    // Flush under hold is ignored; once hold drops the flush empties FULL.
    task automatic test_flush_hold();
        do_reset();
        in_valid = 1'b1; in_data = 8'h31;
        tick();
        in_data = 8'h32;
        tick();
        in_valid = 1'b0;
        flush = 1'b1; hold = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fh_hold_valid: got %0b want 1", out_valid); end
        n_vec++; if (out_data !== 8'h31) begin n_err++; $display("FAIL fh_hold_data: got %0h want 31", out_data); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fh_hold_ready: got %0b want 0", in_ready); end
`ifdef PIPE_STAGE_PERF_EN
        n_vec++; if (flush_cnt !== 3'd0) begin n_err++; $display("FAIL fh_hold_flush_cnt: got %0d want 0", flush_cnt); end
`endif
        hold = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fh_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL fh_data: got %0h want 0", out_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fh_ready: got %0b want 1", in_ready); end
`ifdef PIPE_STAGE_PERF_EN
        n_vec++; if (flush_cnt !== 3'd2) begin n_err++; $display("FAIL fh_flush_cnt: got %0d want 2", flush_cnt); end
`endif
        flush = 1'b0;
    endtask

    // Flush in ONE with a same-cycle accept: the new payload is squashed too.
    task automatic test_flush_accept();
        do_reset();
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22; flush = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fa_valid: got %0b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL fa_data: got %0h want 0", out_data); end
`ifdef PIPE_STAGE_PERF_EN
        n_vec++; if (flush_cnt !== 3'd1) begin n_err++; $display("FAIL fa_flush_cnt: got %0d want 1", flush_cnt); end
`endif
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fa_no_ghost: got %0b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL fa_no_ghost_data: got %0h want 0", out_data); end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    // One payload stalled for 15 cycles: stall_cnt counts up and sticks at 7.
    task automatic test_stall_count();
        do_reset();
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            tick();
            n_vec++;
            if (stall_cnt !== ((k - 1 > 7) ? 3'd7 : CW'(k - 1))) begin
                n_err++;
                $display("FAIL stall_cnt[%0d]: got %0d want %0d", k, stall_cnt, (k - 1 > 7) ? 7 : k - 1);
            end
        end
        n_vec++; if (out_data !== 8'h55) begin n_err++; $display("FAIL stall_data: got %0h want 55", out_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_hold();
        test_flush_accept();
`ifdef PIPE_STAGE_PERF_EN
        test_stall_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_buf
